// File: rtl/mem_responder.sv
// Memory-mapped responder: word RAM, sticky halt register and a free-running
// cycle counter behind a request/ready handshake with configurable wait states.
module mem_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned RAM_WORDS   = 128,
  parameter logic [31:0] HALT_ADDR   = 32'h0000_0400,
  parameter logic [31:0] CYCLE_ADDR  = 32'h0000_0404
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        mem_ready,
  output logic        addr_err,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int unsigned IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned CNT_W     = 4;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {K_RAM, K_HALT, K_CYCLE, K_ERR} kind_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  kind_e              kind_q, kind_in, kind_c;
  logic               rd_q, rd_c;
  logic [IDX_W-1:0]   idx_q, idx_in, idx_c;
  logic [31:0]        wdata_q, snap_q, snap_c;
  logic [31:0]        cyc_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               halt_q;
  logic [31:0]        halt_code_q;
  logic               accept;
  logic [31:0]        ram [RAM_WORDS];

  // Classify the live request; anything not explicitly legal is an error.
  always_comb begin
    kind_in = K_ERR;
    if ((MemRead && MemWrite) || (dAddress[1:0] != 2'b00)) kind_in = K_ERR;
    else if (dAddress < RAM_BYTES)                          kind_in = K_RAM;
    else if (MemWrite && (dAddress == HALT_ADDR))           kind_in = K_HALT;
    else if (MemRead && (dAddress == CYCLE_ADDR))           kind_in = K_CYCLE;
  end

  assign idx_in = dAddress[IDX_W+1:2];

  // With zero wait states the response is formed on the accepting edge,
  // so the live request stands in for the not-yet-latched copy.
  assign kind_c = (state_q == S_IDLE) ? kind_in  : kind_q;
  assign rd_c   = (state_q == S_IDLE) ? MemRead  : rd_q;
  assign idx_c  = (state_q == S_IDLE) ? idx_in   : idx_q;
  assign snap_c = (state_q == S_IDLE) ? cyc_q    : snap_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_RESP);
    err_d   = ready_d && (kind_c == K_ERR);
    rdata_d = rdata_q;
    if (ready_d && rd_c) begin
      case (kind_c)
        K_RAM:   rdata_d = ram[idx_c];
        K_CYCLE: rdata_d = snap_c;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      kind_q      <= K_ERR;
      rd_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      snap_q      <= '0;
      cyc_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_q + 32'd1;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (accept) begin
        kind_q  <= kind_in;
        rd_q    <= MemRead;
        idx_q   <= idx_in;
        wdata_q <= dWriteData;
        snap_q  <= cyc_q;
      end
      if ((state_q == S_RESP) && (kind_q == K_HALT) && !halt_q) begin
        halt_q      <= 1'b1;
        halt_code_q <= wdata_q;
      end
    end
  end

  // Writes commit at the end of the response cycle, so a reset before then drops them.
  always_ff @(posedge clk) begin
    if ((state_q == S_RESP) && (kind_q == K_RAM) && !rd_q) ram[idx_q] <= wdata_q;
  end

  assign dReadData = rdata_q;
  assign mem_ready = ready_q;
  assign addr_err  = err_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a transaction-level model checked every cycle on a
// one-wait-state instance, plus directed literal checks on both instances.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int unsigned WS_A   = 1;
  localparam logic [31:0] HALT_A = 32'h0000_0400;
  localparam logic [31:0] CYC_A  = 32'h0000_0404;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_rd = 1'b0, a_wr = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata, a_code;
  logic        a_ready, a_err, a_halt;

  logic        b_rd = 1'b0, b_wr = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [31:0] b_rdata, b_code;
  logic        b_ready, b_err, b_halt;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(WS_A)) u_a (
    .clk(clk), .rst(rst), .MemRead(a_rd), .MemWrite(a_wr),
    .dAddress(a_addr), .dWriteData(a_wdata), .dReadData(a_rdata),
    .mem_ready(a_ready), .addr_err(a_err), .halt(a_halt), .halt_code(a_code)
  );

  mem_responder #(.WAIT_STATES(0)) u_b (
    .clk(clk), .rst(rst), .MemRead(b_rd), .MemWrite(b_wr),
    .dAddress(b_addr), .dWriteData(b_wdata), .dReadData(b_rdata),
    .mem_ready(b_ready), .addr_err(b_err), .halt(b_halt), .halt_code(b_code)
  );

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of instance A ----------------
  logic [31:0] m_mem [int unsigned];
  bit          m_busy = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_addr = '0, m_data = '0, m_snap = '0, m_cyc = '0;
  bit          e_ready = 1'b0, e_err = 1'b0, e_halt = 1'b0, e_known = 1'b1;
  logic [31:0] e_rdata = '0, e_code = '0;

  function automatic bit is_err(input bit rd, input bit wr, input logic [31:0] addr);
    if (rd && wr)          return 1'b1;
    if (addr[1:0] != 2'b0) return 1'b1;
    if (addr < 32'h200)    return 1'b0;
    if (addr == HALT_A)    return !wr;
    if (addr == CYC_A)     return !rd;
    return 1'b1;
  endfunction

  task automatic m_respond();
    e_ready = 1'b1;
    e_err   = is_err(m_rd, m_wr, m_addr);
    if (m_rd) begin
      if (e_err)                          begin e_rdata = '0;     e_known = 1'b1; end
      else if (m_addr == CYC_A)           begin e_rdata = m_snap; e_known = 1'b1; end
      else if (m_mem.exists(m_addr >> 2)) begin e_rdata = m_mem[m_addr >> 2]; e_known = 1'b1; end
      else                                e_known = 1'b0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; e_ready = 1'b0; e_err = 1'b0; e_rdata = '0; e_known = 1'b1;
      e_halt = 1'b0; e_code = '0; m_cyc = '0;
    end else begin
      if (e_ready) begin
        if (!e_err && m_wr) begin
          if (m_addr == HALT_A) begin
            if (!e_halt) begin e_halt = 1'b1; e_code = m_data; end
          end else m_mem[m_addr >> 2] = m_data;
        end
        e_ready = 1'b0; e_err = 1'b0; m_busy = 1'b0;
      end else if (!m_busy) begin
        if (a_rd || a_wr) begin
          m_rd = a_rd; m_wr = a_wr; m_addr = a_addr; m_data = a_wdata;
          m_snap = m_cyc; m_busy = 1'b1; m_rem = WS_A;
          if (m_rem == 0) m_respond();
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_respond();
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_ready", 32'(a_ready), 32'(e_ready));
      chk("addr_err",  32'(a_err),   32'(e_err));
      chk("halt",      32'(a_halt),  32'(e_halt));
      chk("halt_code", a_code, e_code);
      if (e_known) chk("dReadData", a_rdata, e_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = data; end
    else     begin a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data; end
  endtask

  task automatic do_req(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data, input int start_at,
                        output int acc, output int lat, output logic [31:0] rdata, output logic err);
    bit got;
    got = 1'b0;
    @(negedge clk);
    while (tb_cyc + 1 < start_at) @(negedge clk);
    acc = tb_cyc + 1;
    drive(sel, rd, wr, addr, data);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, ~addr, ~data);
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = sel ? b_ready : a_ready;
    end
    if (!got) chk("ready_timeout", 32'(got), 32'd1);
    rdata = sel ? b_rdata : a_rdata;
    err   = sel ? b_err   : a_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc1, lat;
    logic [31:0] rdv, v1, v2;
    logic err;

    repeat (2) @(negedge clk);
    chk("rst_ready_a", 32'(a_ready), 32'd0);
    chk("rst_rdata_a", a_rdata, 32'd0);
    chk("rst_halt_a",  32'(a_halt), 32'd0);
    chk("rst_ready_b", 32'(b_ready), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // One wait state: write then read back
    do_req(0, 0, 1, 32'h010, 32'hDEADBEEF, 0, acc, lat, rdv, err);
    chk("ws1_wr_lat", 32'(lat), 32'd2);
    chk("ws1_wr_err", 32'(err), 32'd0);
    do_req(0, 1, 0, 32'h010, 32'h0, 0, acc, lat, rdv, err);
    chk("ws1_rd_lat",  32'(lat), 32'd2);
    chk("ws1_rd_data", rdv, 32'hDEADBEEF);
    chk("ws1_rd_err",  32'(err), 32'd0);

    // Zero wait states on instance B
    do_req(1, 0, 1, 32'h1FC, 32'h12345678, 0, acc, lat, rdv, err);
    chk("ws0_wr_lat", 32'(lat), 32'd1);
    do_req(1, 1, 0, 32'h1FC, 32'h0, 0, acc, lat, rdv, err);
    chk("ws0_rd_lat",  32'(lat), 32'd1);
    chk("ws0_rd_data", rdv, 32'h12345678);
    chk("ws0_rd_err",  32'(err), 32'd0);

    // Halt register is sticky
    do_req(0, 0, 1, 32'h400, 32'h00000001, 0, acc, lat, rdv, err);
    chk("halt1_err", 32'(err), 32'd0);
    do_req(0, 0, 1, 32'h400, 32'h00000002, 0, acc, lat, rdv, err);
    chk("halt2_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("halt_set",  32'(a_halt), 32'd1);
    chk("halt_code", a_code, 32'h00000001);

    // Error cases
    do_req(0, 0, 1, 32'h020, 32'h5A5A5A5A, 0, acc, lat, rdv, err);
    do_req(0, 1, 0, 32'h013, 32'h0, 0, acc, lat, rdv, err);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_data", rdv, 32'd0);
    do_req(0, 1, 0, 32'h200, 32'h0, 0, acc, lat, rdv, err);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_data", rdv, 32'd0);
    do_req(0, 1, 1, 32'h020, 32'hFFFFFFFF, 0, acc, lat, rdv, err);
    chk("both_err", 32'(err), 32'd1);
    chk("both_data", rdv, 32'd0);
    do_req(0, 1, 0, 32'h400, 32'h0, 0, acc, lat, rdv, err);
    chk("rd_halt_err", 32'(err), 32'd1);
    do_req(0, 0, 1, 32'h404, 32'h77777777, 0, acc, lat, rdv, err);
    chk("wr_cyc_err", 32'(err), 32'd1);
    do_req(0, 1, 0, 32'h020, 32'h0, 0, acc, lat, rdv, err);
    chk("w20_kept", rdv, 32'h5A5A5A5A);

    // Cycle counter reads 10 cycles apart
    do_req(0, 1, 0, 32'h404, 32'h0, 0, acc1, lat, v1, err);
    do_req(0, 1, 0, 32'h404, 32'h0, acc1 + 10, acc, lat, v2, err);
    chk("cyc_delta", v2 - v1, 32'd10);

    // Reset during WAIT drops the pending write
    do_req(0, 0, 1, 32'h008, 32'h0BADF00D, 0, acc, lat, rdv, err);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h008, 32'hCAFEF00D);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(a_ready), 32'd0);
    chk("rst_mid_err",   32'(a_err),   32'd0);
    chk("rst_mid_rdata", a_rdata, 32'd0);
    chk("rst_mid_halt",  32'(a_halt),  32'd0);
    chk("rst_mid_code",  a_code, 32'd0);
    chk("rst_mid_rdata_b", b_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(0, 1, 0, 32'h008, 32'h0, 0, acc, lat, rdv, err);
    chk("rst_kept_data", rdv, 32'h0BADF00D);
    chk("rst_kept_lat",  32'(lat), 32'd2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
